// File: rtl/ex_stage_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_pipe_pkg
// Description : Shared definitions for the execute stage: default datapath
//               width, ALU op codes, forwarding select codes, destination
//               register select codes and the multiplier state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ex_stage_pipe_pkg;

    localparam int WORD_SIZE_DEF = 16;

    // ALU op codes
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_ORR = 4'd3;
    localparam logic [3:0] ALU_NOT = 4'd4;
    localparam logic [3:0] ALU_TCP = 4'd5;
    localparam logic [3:0] ALU_SHL = 4'd6;
    localparam logic [3:0] ALU_SHR = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;

    // Operand forwarding selects (2'b11 falls back to the register file)
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Destination register selects (2'b11 behaves like RT)
    localparam logic [1:0] RDST_RT   = 2'b00;
    localparam logic [1:0] RDST_RD   = 2'b01;
    localparam logic [1:0] RDST_LINK = 2'b10;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage : ex_stage_pipe_pkg
`default_nettype wire

// File: rtl/ex_stage_pipe_iter_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : iter_multiplier
// Description : Iterative shift-add multiplier returning the low W bits of
//               a*b. The first partial product is formed on the start edge,
//               the remaining W-1 iterations run one per cycle in BUSY, and
//               the result is presented in DONE until released.
// Ports       : clk_i, rst_i (async, active-high)
//               start_i  - latch a_i/b_i and begin (only honoured in IDLE)
//               abort_i  - return to IDLE immediately (beats start/hold)
//               hold_i   - keep DONE while the pipeline is held
//               a_i, b_i - operands
//               busy_o   - iterations in progress
//               done_o   - product_o is valid
//               product_o- low W bits of the product
// Revision    : 1.0 - initial release
// ============================================================================
module iter_multiplier
    import ex_stage_pipe_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic         hold_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] product_o
);

    localparam int CNT_W = $clog2(W + 1);

    mul_state_e       state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= MUL_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (abort_i) begin
            state_d = MUL_IDLE;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (start_i) begin
                        // Iteration 1 happens on the start edge so that the
                        // whole operation fits in W busy cycles.
                        acc_d    = b_i[0] ? a_i : '0;
                        mcand_d  = a_i << 1;
                        mplier_d = b_i >> 1;
                        cnt_d    = CNT_W'(1);
                        state_d  = MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(W - 1)) begin
                        state_d = MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    if (!hold_i) begin
                        state_d = MUL_IDLE;
                    end
                end
                default: state_d = MUL_IDLE;
            endcase
        end
    end

    assign busy_o    = (state_q == MUL_BUSY);
    assign done_o    = (state_q == MUL_DONE);
    assign product_o = acc_q;

endmodule : iter_multiplier
`default_nettype wire

// File: rtl/ex_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_pipe
// Description : Execute stage of the 16-bit core. Holds the ID/EX register,
//               the operand forwarding muxes, the ALU and (optionally) an
//               iterative multiplier that back-pressures upstream.
// Ports       : clk_i, reset_i (async, active-high)
//               in_valid_i, stall_i, flush_i - pipeline control
//               pc_i, read_data1_i, read_data2_i, imm_ext_i - ID operands
//               rs_i, rt_i, rd_i - register indices
//               alu_op_i, alu_src_i, is_lhi_i, reg_dest_i - EX control
//               mem_read_i, mem_write_i, reg_write_i, reg_write_src_i - passed on
//               fwd_a_i, fwd_b_i, mem_fwd_data_i, wb_fwd_data_i - forwarding
//               out_valid_o, alu_out_o, store_data_o, pc_val_o,
//               reg_write_target_o, rs_out_o, rt_out_o, mem_read_out_o,
//               mem_write_out_o, reg_write_out_o, reg_write_src_out_o,
//               ex_busy_o - results and downstream control
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage_pipe
    import ex_stage_pipe_pkg::*;
#(
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int REG_ADDR_W = 2,
    parameter int LINK_REG   = 2,
    parameter int MUL_EN     = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  in_valid_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [WORD_SIZE-1:0]  pc_i,
    input  logic [WORD_SIZE-1:0]  read_data1_i,
    input  logic [WORD_SIZE-1:0]  read_data2_i,
    input  logic [WORD_SIZE-1:0]  imm_ext_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rt_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [3:0]            alu_op_i,
    input  logic                  alu_src_i,
    input  logic                  is_lhi_i,
    input  logic [1:0]            reg_dest_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic                  reg_write_i,
    input  logic [1:0]            reg_write_src_i,
    input  logic [1:0]            fwd_a_i,
    input  logic [1:0]            fwd_b_i,
    input  logic [WORD_SIZE-1:0]  mem_fwd_data_i,
    input  logic [WORD_SIZE-1:0]  wb_fwd_data_i,
    output logic                  out_valid_o,
    output logic [WORD_SIZE-1:0]  alu_out_o,
    output logic [WORD_SIZE-1:0]  store_data_o,
    output logic [WORD_SIZE-1:0]  pc_val_o,
    output logic [REG_ADDR_W-1:0] reg_write_target_o,
    output logic [REG_ADDR_W-1:0] rs_out_o,
    output logic [REG_ADDR_W-1:0] rt_out_o,
    output logic                  mem_read_out_o,
    output logic                  mem_write_out_o,
    output logic                  reg_write_out_o,
    output logic [1:0]            reg_write_src_out_o,
    output logic                  ex_busy_o
);

    localparam int HALF = WORD_SIZE / 2;

    // ID/EX register: control bits that a flush must kill
    logic valid_q, valid_d;
    logic mem_read_q, mem_read_d;
    logic mem_write_q, mem_write_d;
    logic reg_write_q, reg_write_d;

    // ID/EX register: payload (don't-care after a flush, so only loaded)
    logic [WORD_SIZE-1:0]  pc_q, rd1_q, rd2_q, imm_q;
    logic [REG_ADDR_W-1:0] rs_q, rt_q, rd_q;
    logic [3:0]            alu_op_q;
    logic                  alu_src_q, is_lhi_q;
    logic [1:0]            reg_dest_q, reg_write_src_q;

    logic                  w_hold;
    logic                  w_load;
    logic [WORD_SIZE-1:0]  w_a, w_b_fwd, w_b;
    logic [WORD_SIZE-1:0]  w_alu_res;
    logic                  w_mul_op;
    logic                  w_mul_start;
    logic                  w_mul_done;
    logic [WORD_SIZE-1:0]  w_mul_res;

    assign w_hold = stall_i | ex_busy_o;
    assign w_load = !flush_i && !w_hold;

    always_comb begin
        valid_d     = valid_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        reg_write_d = reg_write_q;
        if (flush_i) begin
            valid_d     = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            reg_write_d = 1'b0;
        end else if (!w_hold) begin
            valid_d     = in_valid_i;
            mem_read_d  = mem_read_i;
            mem_write_d = mem_write_i;
            reg_write_d = reg_write_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q         <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            reg_write_q     <= 1'b0;
            pc_q            <= '0;
            rd1_q           <= '0;
            rd2_q           <= '0;
            imm_q           <= '0;
            rs_q            <= '0;
            rt_q            <= '0;
            rd_q            <= '0;
            alu_op_q        <= '0;
            alu_src_q       <= 1'b0;
            is_lhi_q        <= 1'b0;
            reg_dest_q      <= '0;
            reg_write_src_q <= '0;
        end else begin
            valid_q     <= valid_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            reg_write_q <= reg_write_d;
            if (w_load) begin
                pc_q            <= pc_i;
                rd1_q           <= read_data1_i;
                rd2_q           <= read_data2_i;
                imm_q           <= imm_ext_i;
                rs_q            <= rs_i;
                rt_q            <= rt_i;
                rd_q            <= rd_i;
                alu_op_q        <= alu_op_i;
                alu_src_q       <= alu_src_i;
                is_lhi_q        <= is_lhi_i;
                reg_dest_q      <= reg_dest_i;
                reg_write_src_q <= reg_write_src_i;
            end
        end
    end

    // Operand forwarding
    always_comb begin
        case (fwd_a_i)
            FWD_MEM: w_a = mem_fwd_data_i;
            FWD_WB:  w_a = wb_fwd_data_i;
            default: w_a = rd1_q;
        endcase
        case (fwd_b_i)
            FWD_MEM: w_b_fwd = mem_fwd_data_i;
            FWD_WB:  w_b_fwd = wb_fwd_data_i;
            default: w_b_fwd = rd2_q;
        endcase
        w_b = alu_src_q ? imm_q : w_b_fwd;
    end

    // LHI takes precedence, so an LHI with a MUL op code is not a multiply
    assign w_mul_op = !is_lhi_q && (alu_op_q == ALU_MUL);

    generate
        if (MUL_EN != 0) begin : g_mul
            logic w_busy;
            logic [WORD_SIZE-1:0] w_product;

            // start is only acted on in IDLE; in DONE the same instruction
            // is still in the register but must not restart.
            assign w_mul_start = valid_q && w_mul_op && !w_busy && !w_mul_done;

            iter_multiplier #(
                .W (WORD_SIZE)
            ) u_mul (
                .clk_i     (clk_i),
                .rst_i     (reset_i),
                .start_i   (w_mul_start),
                .abort_i   (flush_i),
                .hold_i    (stall_i),
                .a_i       (w_a),
                .b_i       (w_b),
                .busy_o    (w_busy),
                .done_o    (w_mul_done),
                .product_o (w_product)
            );

            assign ex_busy_o = w_mul_start | w_busy;
            assign w_mul_res = w_mul_done ? w_product : '0;
        end else begin : g_no_mul
            assign w_mul_start = 1'b0;
            assign w_mul_done  = 1'b0;
            assign ex_busy_o   = 1'b0;
            assign w_mul_res   = '0;
        end
    endgenerate

    // ALU
    always_comb begin
        w_alu_res = '0;
        if (is_lhi_q) begin
            w_alu_res = {imm_q[HALF-1:0], {(WORD_SIZE - HALF){1'b0}}};
        end else begin
            case (alu_op_q)
                ALU_ADD: w_alu_res = w_a + w_b;
                ALU_SUB: w_alu_res = w_a - w_b;
                ALU_AND: w_alu_res = w_a & w_b;
                ALU_ORR: w_alu_res = w_a | w_b;
                ALU_NOT: w_alu_res = ~w_a;
                ALU_TCP: w_alu_res = '0 - w_a;
                ALU_SHL: w_alu_res = w_a << 1;
                ALU_SHR: w_alu_res = {w_a[WORD_SIZE-1], w_a[WORD_SIZE-1:1]};
                ALU_MUL: w_alu_res = w_mul_res;
                default: w_alu_res = '0;
            endcase
        end
    end

    // With the multiplier present a MUL is only valid once DONE
    assign out_valid_o = valid_q && (!w_mul_op || (MUL_EN == 0) || w_mul_done);

    always_comb begin
        case (reg_dest_q)
            RDST_RD:   reg_write_target_o = rd_q;
            RDST_LINK: reg_write_target_o = REG_ADDR_W'(LINK_REG);
            default:   reg_write_target_o = rt_q;
        endcase
    end

    assign alu_out_o           = w_alu_res;
    assign store_data_o        = w_b_fwd;
    assign pc_val_o            = pc_q;
    assign rs_out_o            = rs_q;
    assign rt_out_o            = rt_q;
    assign mem_read_out_o      = mem_read_q  & out_valid_o;
    assign mem_write_out_o     = mem_write_q & out_valid_o;
    assign reg_write_out_o     = reg_write_q & out_valid_o;
    assign reg_write_src_out_o = reg_write_src_q;

endmodule : ex_stage_pipe
`default_nettype wire

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
- Parametrised execute stage for the pipelined 16-bit core: owns the ID/EX pipeline register, operand-forwarding muxes, ALU, and an optional iterative multiplier.
- Adds stall, flush, valid tracking and a multi-cycle MUL path that back-pressures the hazard unit.
- Sits between decode (ID) and the EX/MEM register. MEM/WB control bits pass through registered.

Parameters:
- WORD_SIZE, 16, datapath width.
- REG_ADDR_W, 2, register-index width.
- LINK_REG, 2, register index written when RegDest=2'b10 (JAL/JRL).
- MUL_EN, 1, 1 = iterative multiplier present; 0 = MUL opcode yields 0 in 1 cycle.

Ports:
- clk, in, 1, rising-edge clock.
- reset, in, 1, asynchronous, active-high; clears all state.
- in_valid, in, 1, ID holds a real instruction.
- stall, in, 1, hazard unit: hold ID/EX contents.
- flush, in, 1, squash ID/EX (branch mispredict); wins over stall.
- pc, read_data1, read_data2, imm_ext, in, WORD_SIZE each, ID operands.
- rs, rt, rd, in, REG_ADDR_W each, register indices.
- alu_op, in, 4, op code: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 NOT, 5 TCP, 6 SHL, 7 SHR, 8 MUL; others give 0.
- alu_src, in, 1, B operand = imm_ext.
- is_lhi, in, 1, result = {imm_ext[WORD_SIZE/2-1:0], zeros}.
- reg_dest, in, 2, 00 rt, 01 rd, 10 LINK_REG, 11 rt.
- mem_read, mem_write, reg_write, in, 1 each; reg_write_src, in, 2, passed through.
- fwd_a, fwd_b, in, 2 each, 00 register file, 01 mem_fwd_data, 10 wb_fwd_data, 11 register file.
- mem_fwd_data, wb_fwd_data, in, WORD_SIZE each.
- out_valid, out, 1, result valid this cycle.
- alu_out, out, WORD_SIZE; store_data, out, WORD_SIZE (forwarded B before the alu_src mux).
- pc_val, out, WORD_SIZE; reg_write_target, out, REG_ADDR_W.
- rs_out, rt_out, out, REG_ADDR_W each, to the forwarding unit.
- mem_read_out, mem_write_out, reg_write_out, out, 1 each; reg_write_src_out, out, 2.
- ex_busy, out, 1, multiplier running; upstream must stall.

Behaviour:
- Reset: all ID/EX fields 0, FSM IDLE. Every output is 0, including out_valid and ex_busy.
- Register update priority, per edge:
  1. reset.
  2. flush: valid, mem_read, mem_write and reg_write are cleared; other fields are don't-care. A running multiply is aborted and the FSM goes to IDLE.
  3. stall or ex_busy: hold all fields.
  4. Otherwise load all inputs; valid <= in_valid.
- Datapath:
  - A = fwd_a mux; B_fwd = fwd_b mux; B = alu_src ? imm_ext : B_fwd.
  - Forwarding is combinational on registered indices and sampled every cycle.
- Non-MUL ops: alu_out is combinational in the same cycle as the register contents. out_valid = valid.
  - ADD/SUB wrap modulo 2^WORD_SIZE.
  - SHL is logical; SHR is arithmetic, 1 bit.
  - NOT = ~A; TCP = -A.
- Control gating: mem_*_out and reg_write_out are gated by out_valid, so a bubble never writes.
- Multiplier FSM (MUL_EN=1): states IDLE, BUSY, DONE.
  - IDLE -> BUSY: on the cycle a valid MUL is present in the register, A and B are latched. ex_busy rises combinationally in that cycle.
  - BUSY: runs WORD_SIZE shift-add iterations, one per cycle. ex_busy=1 and out_valid=0.
  - BUSY -> DONE: after the last iteration. In DONE, alu_out = low WORD_SIZE bits of the product, out_valid=1, ex_busy=0.
  - DONE -> IDLE: on the next edge that does not hold. The ID/EX register loads in that same edge.
  - Total: a MUL occupies WORD_SIZE+1 cycles in EX.
- Operand stability: forwarding changes during BUSY do not affect the product.
- stall asserted while in DONE: hold DONE; output stays valid.
- is_lhi overrides alu_op.
- reg_write_target is decoded from the registered reg_dest.

Decomposition:
- Shared package / `include opcodes.v holds: WORD_SIZE default, ALU op codes, fwd select codes, reg_dest codes, FSM state encoding.
- One sub-module: iter_multiplier (start, a, b, busy, done, product, abort).
  - Reused by a future divider slot.
- ALU stays inline.

Test Plan:
1. Reset mid-MUL:
   - Stimulus: load MUL 7*9, assert reset on BUSY cycle 5.
   - Required: all outputs 0 immediately; ex_busy=0; next instruction executes normally.
2. Forwarding:
   - Stimulus: ADD, read_data1=3, fwd_a=01, mem_fwd_data=0x0010, fwd_b=10, wb_fwd_data=0x0005.
   - Required: alu_out=0x0015, out_valid=1.
3. MUL timing:
   - Stimulus: A=0x0102, B=0x0003.
   - Required: ex_busy=1 for 16 cycles starting the cycle the MUL is in the register; then DONE with alu_out=0x0306, out_valid=1.
   - Also: changing wb_fwd_data during BUSY has no effect.
4. Flush versus stall:
   - Stimulus: stall=1 and flush=1 on the same edge, with a SW in the register.
   - Required: out_valid=0, mem_write_out=0; pc_val unchecked.
5. Wrap and LHI:
   - Stimulus: ADD 0xFFFF+0x0002. Required: 0x0001.
   - Stimulus: is_lhi with imm_ext=0x00AB. Required: 0xAB00.
   - Stimulus: reg_dest=10. Required: reg_write_target=2.
6. MUL_EN=0 build:
   - Stimulus: MUL.
   - Required: alu_out=0, ex_busy never asserts, single-cycle out_valid.
